// File: rtl/mem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM
// states and the alignment rule used by the lane logic.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // True when the access cannot be served: reserved size, or a half/word
  // whose byte offset does not match its natural alignment.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the EX/MEM stage and the data memory.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; all req_* fields are sampled on that edge only.
// req_valid asserted while req_ready is 0 is ignored (nothing is queued).
// Each accepted request produces exactly one rsp_valid pulse lasting one
// cycle; rsp_rdata/rsp_err are valid with it and hold until the next pulse.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 12
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store byte enables and lane-replicated
// store data, load extraction with sign/zero extension, and the error flag.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] rdata,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(word >> {addr_lo, 3'b000});
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  // Lane selection and load extension; an erroring access enables no lanes
  // and returns zero data.
  always_comb begin
    err    = is_bad_access(size, addr_lo);
    be     = 4'b0000;
    wlanes = 32'h0;
    rdata  = 32'h0;
    case (size)
      SZ_BYTE: begin
        be     = 4'b0001 << addr_lo;
        wlanes = {4{wdata[7:0]}};
        rdata  = zero_ext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata[15:0]}};
        rdata  = zero_ext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        be     = 4'b1111;
        wlanes = wdata;
        rdata  = word;
      end
      default: begin
        be     = 4'b0000;
        wlanes = 32'h0;
        rdata  = 32'h0;
      end
    endcase
    if (err) begin
      be    = 4'b0000;
      rdata = 32'h0;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory for the MIPS datapath: clears itself after reset, then serves
// one byte/half/word access at a time with LATENCY wait states and a
// single-cycle response pulse.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_ctrl_if.slave    bus,
  output logic              init_done,
  output state_t            dbg_state
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [3:0] WAIT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  sweep_cnt;
  logic [3:0]        wait_cnt;

  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_uns;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH];

  logic              take;
  logic              fire;
  logic              cur_we;
  logic [1:0]        cur_size;
  logic              cur_uns;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [31:0]       rd_word;
  logic [3:0]        be;
  logic [31:0]       wlanes;
  logic [31:0]       ld_data;
  logic              acc_err;

  assign take = (state == ST_IDLE) && bus.req_valid;
  // The response edge is the one that moves the FSM into RESP.
  assign fire = (state != ST_RESP) && (state_nxt == ST_RESP);

  // With zero wait states the response edge is also the accepting edge, so
  // the datapath looks at the live request while idle, the latch otherwise.
  assign cur_we    = (state == ST_IDLE) ? bus.req_we       : lat_we;
  assign cur_size  = (state == ST_IDLE) ? bus.req_size     : lat_size;
  assign cur_uns   = (state == ST_IDLE) ? bus.req_unsigned : lat_uns;
  assign cur_addr  = (state == ST_IDLE) ? bus.req_addr     : lat_addr;
  assign cur_wdata = (state == ST_IDLE) ? bus.req_wdata    : lat_wdata;

  assign rd_word = mem[cur_addr[ADDR_W-1:2]];

  mem_lane_align u_align (
    .size     (cur_size),
    .zero_ext (cur_uns),
    .addr_lo  (cur_addr[1:0]),
    .wdata    (cur_wdata),
    .word     (rd_word),
    .be       (be),
    .wlanes   (wlanes),
    .rdata    (ld_data),
    .err      (acc_err)
  );

  // Next-state logic: sweep, accept, count wait states, respond.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (sweep_cnt == '1) state_nxt = ST_IDLE;
      ST_IDLE: if (take) state_nxt = (LATENCY > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  // State, counters, request latch and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_size  <= SZ_BYTE;
      lat_uns   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) sweep_cnt <= sweep_cnt + 1'b1;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 4'd1 : 4'd0;
      if (take) begin
        lat_we    <= bus.req_we;
        lat_size  <= bus.req_size;
        lat_uns   <= bus.req_unsigned;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end
      if (fire) begin
        rdata_q <= cur_we ? 32'h0 : ld_data;
        err_q   <= acc_err;
      end
    end
  end

  // Word array: zeroed one word per cycle during the sweep, byte-lane store
  // on the response edge. Nothing is written while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_INIT) begin
        mem[sweep_cnt] <= 32'h0;
      end else if (fire && cur_we && !acc_err) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[cur_addr[ADDR_W-1:2]][8*i +: 8] <= wlanes[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign init_done     = (state != ST_INIT);
  assign dbg_state     = state;

endmodule
